aer_rr_transmitter: RTL and testbench

//  Parametrised AER event transmitter for NUM_CH channels, each with up and down spike inputs.

---
 rtl/aer_pkg.sv | 19 +
 rtl/aer_rr_arbiter.sv | 32 +++
 rtl/aer_rr_transmitter.sv | 168 ++++++++++++++++
 tb/tb_aer_rr_transmitter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared state encoding, polarity constants and address helper for the AER transmitter.
package aer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } aer_state_e;

    localparam logic POL_UP   = 1'b1;
    localparam logic POL_DOWN = 1'b0;

    // Source index and wire address share one encoding: channel above, polarity in the LSB.
    function automatic int unsigned aer_addr(input int unsigned ch, input logic pol);
        return (ch << 1) | {31'd0, pol};
    endfunction

endpackage

// File: rtl/aer_rr_arbiter.sv
// Combinational round-robin scan: first pending source at or above ptr, wrapping at S.
module aer_rr_arbiter #(
    parameter int S     = 8,
    parameter int IDX_W = $clog2(S)
) (
    input  logic [S-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int k;
        logic [IDX_W-1:0] kidx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        k           = 0;
        kidx        = '0;
        for (int i = 0; i < S; i++) begin
            k = int'(ptr) + i;
            if (k >= S) begin
                k = k - S;
            end
            kidx = k[IDX_W-1:0];
            if (!grant_valid && pending[kidx]) begin
                grant_valid = 1'b1;
                grant_idx   = kidx;
            end
        end
    end

endmodule

// File: rtl/aer_rr_transmitter.sv
// AER event transmitter: edge capture, round-robin arbitration, 4-phase req/ack link.
// Optional REQ abort timer is compiled in with `define AER_TIMEOUT_EN.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | link quiet; grant when something is pending and ack_sync low
//  SETUP   | addr driven, req still low (bundled-data setup cycle)
//  REQ     | req high, waiting for ack_sync (or timer expiry)
//  RELEASE | req low, waiting for the receiver to drop ack
module aer_rr_transmitter
    import aer_pkg::*;
#(
    parameter  int NUM_CH          = 4,
    parameter  int ACK_SYNC_STAGES = 2,
    parameter  int TIMEOUT_CYCLES  = 1024,
    localparam int ADDR_W          = $clog2(NUM_CH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ev_up,
    input  logic [NUM_CH-1:0] ev_down,
    input  logic              ack,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int                S        = 2 * NUM_CH;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(S - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    if (NUM_CH < 2) begin : g_chk_num_ch
        $error("aer_rr_transmitter: NUM_CH must be at least 2");
    end
    if (ACK_SYNC_STAGES < 2) begin : g_chk_sync
        $error("aer_rr_transmitter: ACK_SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
        $error("aer_rr_transmitter: TIMEOUT_CYCLES must be at least 1");
    end

    aer_state_e                 state, state_n;
    logic [ACK_SYNC_STAGES-1:0] ack_sq;
    logic                       ack_sync;
    logic [S-1:0]               src_lvl, src_q, src_rise;
    logic [S-1:0]               pending, clr_vec;
    logic [ADDR_W-1:0]          ptr, grant_idx;
    logic                       grant_valid, grant_take;
    logic                       tmo_tc;

    assign ack_sync = ack_sq[ACK_SYNC_STAGES-1];

    always_comb begin
        src_lvl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            src_lvl[aer_addr(c, POL_UP)]   = ev_up[c];
            src_lvl[aer_addr(c, POL_DOWN)] = ev_down[c];
        end
    end

    assign src_rise = src_lvl & ~src_q;

    always_comb begin
        clr_vec = '0;
        if (grant_take) begin
            clr_vec[grant_idx] = 1'b1;
        end
    end

    aer_rr_arbiter #(
        .S     (S),
        .IDX_W (ADDR_W)
    ) u_arb (
        .pending     (pending),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ack_sq   <= '0;
            src_q    <= '0;
            pending  <= '0;
            ptr      <= '0;
            addr     <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            ack_sq   <= {ack_sq[ACK_SYNC_STAGES-2:0], ack};
            src_q    <= src_lvl;
            // A new edge on the source being granted this cycle stays pending.
            pending  <= (pending & ~clr_vec) | src_rise;
            overflow <= |(src_rise & pending & ~clr_vec);
            if (grant_take) begin
                addr <= grant_idx;
                ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ONE_IDX;
            end
        end
    end

`ifdef AER_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_fire;

    assign tmo_tc   = (tmo_cnt == '0);
    assign tmo_fire = (state == ST_REQ) && !ack_sync && tmo_tc;

    // Loaded in SETUP so the count starts fresh on every REQ entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire;
            if (state == ST_SETUP) begin
                tmo_cnt <= TMO_LOAD;
            end else if (state == ST_REQ && !tmo_tc) begin
                tmo_cnt <= tmo_cnt - TMO_ONE;
            end
        end
    end
`else
    assign tmo_tc      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        grant_take = 1'b0;
        case (state)
            ST_IDLE: begin
                // Never restart while the receiver still holds ack from a prior transfer.
                if (grant_valid && !ack_sync) begin
                    grant_take = 1'b1;
                    state_n    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_n = ST_REQ;
            end
            ST_REQ: begin
                if (ack_sync || tmo_tc) begin
                    state_n = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign req  = (state == ST_REQ);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_aer_rr_transmitter.sv
// Scoreboard bench for aer_rr_transmitter (NUM_CH=2); expected addresses are queued at stimulus time.
module tb_aer_rr_transmitter;

    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 2;
    localparam int RX_AUTO = 0;
    localparam int RX_LOW  = 1;
    localparam int RX_HIGH = 2;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic [NUM_CH-1:0] ev_up   = '0;
    logic [NUM_CH-1:0] ev_down = '0;
    logic              ack     = 1'b0;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              overflow;
    logic              timeout_err;

    int          checks    = 0;
    int          failures  = 0;
    int unsigned exp_q[$];
    int          hs_count  = 0;
    int          ovf_count = 0;
    int          ovf_wide  = 0;
    int          tmo_count = 0;
    int          rx_mode   = RX_AUTO;
    int          ack_delay = 3;
    int          rx_cnt    = 0;
    logic              req_prev  = 1'b0;
    logic              ovf_prev  = 1'b0;
    logic [ADDR_W-1:0] addr_prev = '0;

    aer_rr_transmitter #(
        .NUM_CH          (NUM_CH),
        .ACK_SYNC_STAGES (2),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ev_up       (ev_up),
        .ev_down     (ev_down),
        .ack         (ack),
        .req         (req),
        .addr        (addr),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Monitor: every rising req is a handshake and must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (req && !req_prev) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_req_queue_size", exp_q.size(), 1);
                end else begin
                    chk("grant_addr", addr, exp_q.pop_front());
                end
                chk("addr_stable_before_req", addr_prev, addr);
            end
            if (overflow) ovf_count++;
            if (overflow && ovf_prev) ovf_wide++;
            if (timeout_err) tmo_count++;
        end
        req_prev  = req;
        addr_prev = addr;
        ovf_prev  = overflow;
    end

    // Receiver model.
    always @(negedge clk) begin
        if (rx_mode == RX_AUTO) begin
            if (req) begin
                rx_cnt++;
                if (rx_cnt >= ack_delay) ack = 1'b1;
            end else begin
                rx_cnt = 0;
                ack    = 1'b0;
            end
        end else if (rx_mode == RX_LOW) begin
            rx_cnt = 0;
            ack    = 1'b0;
        end else begin
            ack = 1'b1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] up, input logic [NUM_CH-1:0] dn);
        ev_up   = up;
        ev_down = dn;
        step();
        ev_up   = '0;
        ev_down = '0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ev_up   = '0;
        ev_down = '0;
        rx_mode = RX_AUTO;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            step();
            n++;
        end
        if (hs_count < target) chk("handshake_wait_expired", hs_count, target);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int n, h0, o0, t0;

        // Reset state
        step();
        step();
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        step();

        // 1: single up event on ch0, ack 3 cycles after req
        ack_delay = 3;
        exp_q.push_back(1);
        ev_up = 2'b01;
        step();
        ev_up = '0;
        chk("t1_req_at_k", req, 0);
        chk("t1_busy_at_k", busy, 0);
        step();
        chk("t1_busy_setup", busy, 1);
        chk("t1_addr_setup", addr, 1);
        chk("t1_req_setup", req, 0);
        step();
        chk("t1_req_high", req, 1);
        n = 0;
        while (!ack && n < 20) begin
            step();
            n++;
        end
        chk("t1_ack_seen", ack, 1);
        n = 0;
        do begin
            step();
            n++;
        end while (req && n < 20);
        chk("t1_req_fall_cycles", n, 3);
        chk("t1_busy_release", busy, 1);
        drain("t1", 30);

        // 2: simultaneous sources, then pointer wrap
        do_reset();
        exp_q.push_back(1);
        exp_q.push_back(2);
        pulse(2'b01, 2'b10);
        drain("t2a", 80);
        exp_q.push_back(0);
        exp_q.push_back(1);
        pulse(2'b01, 2'b01);
        drain("t2b", 80);

        // 3: overflow while ack held low
        rx_mode = RX_LOW;
        h0 = hs_count;
        o0 = ovf_count;
        exp_q.push_back(1);
        exp_q.push_back(1);
        pulse(2'b01, 2'b00);
        repeat (4) step();
        chk("t3_req_waiting", req, 1);
        pulse(2'b01, 2'b00);
        repeat (2) step();
        chk("t3_no_overflow_yet", ovf_count - o0, 0);
        pulse(2'b01, 2'b00);
        repeat (3) step();
        chk("t3_overflow_pulses", ovf_count - o0, 1);
        chk("t3_overflow_width", ovf_wide, 0);
        rx_mode = RX_AUTO;
        drain("t3", 100);
        chk("t3_handshakes", hs_count - h0, 2);

        // 4: reset mid-handshake with ack high
        do_reset();
        rx_mode = RX_LOW;
        h0 = hs_count;
        exp_q.push_back(3);
        pulse(2'b10, 2'b00);
        wait_hs(h0 + 1, 20);
        pulse(2'b00, 2'b10);
        rx_mode = RX_HIGH;
        step();
        reset = 1'b1;
        step();
        chk("t4_req_after_reset", req, 0);
        chk("t4_busy_after_reset", busy, 0);
        reset = 1'b0;
        repeat (4) step();
        exp_q.push_back(1);
        pulse(2'b01, 2'b00);
        n = 0;
        repeat (6) begin
            step();
            if (req || busy) n++;
        end
        chk("t4_no_grant_while_ack", n, 0);
        rx_mode = RX_AUTO;
        drain("t4", 80);
        chk("t4_handshakes", hs_count - h0, 2);

        // 5: REQ with no ack
        do_reset();
        rx_mode = RX_LOW;
        h0 = hs_count;
        t0 = tmo_count;
        exp_q.push_back(1);
        pulse(2'b01, 2'b00);
        wait_hs(h0 + 1, 20);
`ifdef AER_TIMEOUT_EN
        n = 0;
        while (req && n < 100) begin
            n++;
            step();
        end
        chk("t5_req_high_cycles", n, 8);
        repeat (2) step();
        chk("t5_timeout_pulses", tmo_count - t0, 1);
`else
        repeat (40) step();
        chk("t5_req_still_high", req, 1);
        chk("t5_no_timeout", tmo_count - t0, 0);
`endif
        rx_mode = RX_AUTO;
        drain("t5", 60);

        // 6: all four sources re-fire on every handshake
        do_reset();
        h0 = hs_count;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        pulse(2'b11, 2'b11);
        for (int i = 1; i <= 4; i++) begin
            wait_hs(h0 + i, 60);
            pulse(2'b11, 2'b11);
        end
        drain("t6", 300);
        chk("t6_handshakes", hs_count - h0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
